band_fetch: RTL and testbench



---
 rtl/band_fetch_if.sv | 23 ++
 rtl/band_fetch.sv | 126 ++++++++++++
 tb/tb_band_fetch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/band_fetch_if.sv
// Fetch-side bus of band_fetch: image-memory read port plus the pixel stream
// into the line-buffer stage.
interface band_fetch_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        data;
  logic              fetch_en;
  logic              band_done;
  logic              frame_done;

  modport master (
    output mem_rd, mem_addr, data, fetch_en, band_done, frame_done,
    input  mem_data
  );

  modport slave (
    input  mem_rd, mem_addr, data, fetch_en, band_done, frame_done,
    output mem_data
  );
endinterface

// File: rtl/band_fetch.sv
// Image-memory read sequencer: primes a 3-row line buffer, then streams one
// row per controller request until the last image row has been sent.
module band_fetch #(
  parameter int IMG_COLS  = 540,
  parameter int IMG_ROWS  = 540,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         next_i,
  band_fetch_if.master fb,
  output logic         busy_o,
  output logic [9:0]   row_cnt_o
);

  localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_LINE
  } state_t;

  state_t            state_q;
  logic [9:0]        row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              fetch_en_q;
  logic              band_done_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              col_last_d;
  logic              row_last_d;

  assign col_last_d = (col_q == COL_W'(IMG_COLS - 1));
  assign row_last_d = (row_q == 10'(IMG_ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      fetch_en_q   <= 1'b0;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fetch_en_q   <= rd_q;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;

      if (rd_q) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (col_last_d) begin
          col_q <= '0;
          row_q <= row_q + 10'd1;
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      case (state_q)
        // busy_q lags the final IDLE entry by one cycle so it covers the last data beat
        S_IDLE: begin
          if (start_i && !busy_q) begin
            state_q <= S_PRIME;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_PRIME: begin
          if (col_last_d && row_q == 10'd2) begin
            rd_q        <= 1'b0;
            band_done_q <= 1'b1;
            if (IMG_ROWS == 3) begin
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              state_q      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (next_i) begin
            state_q <= S_LINE;
            rd_q    <= 1'b1;
          end
        end
        S_LINE: begin
          if (col_last_d) begin
            rd_q        <= 1'b0;
            band_done_q <= 1'b1;
            if (row_last_d) begin
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              state_q      <= S_WAIT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fb.mem_rd     = rd_q;
  assign fb.mem_addr   = addr_q;
  assign fb.fetch_en   = fetch_en_q;
  assign fb.data       = fetch_en_q ? fb.mem_data : 8'd0;
  assign fb.band_done  = band_done_q;
  assign fb.frame_done = frame_done_q;
  assign busy_o        = busy_q;
  assign row_cnt_o     = row_q;

endmodule

// File: tb/tb_band_fetch.sv
// Self-checking bench for band_fetch: randomized controller timing and stray
// control pulses, checked against a frame-level model of the pixel stream.
module tb_band_fetch;
  localparam int COLS = 4;
  localparam int ROWS = 5;
  localparam int AW   = 19;
  localparam int BASE = 0;
  localparam int N    = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       next_i = 1'b0;
  logic       busy;
  logic [9:0] row_cnt;
  int         errors = 0;
  int         checks = 0;

  band_fetch_if #(.ADDR_W(AW)) bus ();

  band_fetch #(
    .IMG_COLS(COLS), .IMG_ROWS(ROWS), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .next_i(next_i),
    .fb(bus.master), .busy_o(busy), .row_cnt_o(row_cnt)
  );

  always #5 clk = ~clk;

  // memory[a] = a; garbage when no read so ungated data would show
  always @(posedge clk) bus.mem_data <= bus.mem_rd ? bus.mem_addr[7:0] : 8'($urandom);

  // band 0 is the 3-row prime, every later band is one row
  function automatic int band_of(input int i);
    return (i < 3 * COLS) ? 0 : (i - 3 * COLS) / COLS + 1;
  endfunction

  function automatic bit is_band_last(input int i);
    return (i == N - 1) || (band_of(i) != band_of(i + 1));
  endfunction

  task automatic run_frame(input int max_dly, input bit noise, input bit with_next, input string tag);
    logic [AW-1:0] raddr[$];
    logic [7:0]    dat[$];
    int            rcyc[$];
    int            fcyc[$];
    bit            bd[$];
    bit            fd[$];
    int stray = 0, dly = 0, cyc = 0, fd_cyc = -1, idle_cyc = -1, nr, nd;
    bit reading = 1'b1, done = 1'b0, timeout = 1'b1;
    start_i = 1'b1;
    next_i  = with_next;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      next_i  = 1'b0;
      if (bus.mem_rd === 1'b1) begin raddr.push_back(bus.mem_addr); rcyc.push_back(cyc); end
      if (bus.fetch_en === 1'b1) begin
        dat.push_back(bus.data); fcyc.push_back(cyc);
        bd.push_back(bus.band_done); fd.push_back(bus.frame_done);
      end else if (bus.data !== 8'd0 || bus.band_done !== 1'b0 || bus.frame_done !== 1'b0) begin
        stray++;
      end
      if (done && busy === 1'b0) begin
        idle_cyc = cyc; timeout = 1'b0; break;
      end else if (bus.frame_done === 1'b1) begin
        done = 1'b1; fd_cyc = cyc; start_i = noise;
      end else begin
        if (bus.band_done === 1'b1) begin reading = 1'b0; dly = $urandom_range(max_dly, 0); end
        if (!reading) begin
          if (dly == 0) begin next_i = 1'b1; reading = 1'b1; end
          else dly--;
        end else if (noise) begin
          next_i  = ($urandom_range(2, 0) == 0);
          start_i = ($urandom_range(2, 0) == 0);
        end
      end
    end
    start_i = 1'b0;
    next_i  = 1'b0;

    checks++; if (timeout) begin errors++; $display("FAIL %s timeout: frame did not complete, busy=%b", tag, busy); end
    checks++; if (raddr.size() !== N) begin errors++; $display("FAIL %s read_count: got %0d want %0d", tag, raddr.size(), N); end
    checks++; if (dat.size() !== N) begin errors++; $display("FAIL %s pixel_count: got %0d want %0d", tag, dat.size(), N); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL %s idle_outputs: %0d non-zero cycles without fetch_en, want 0", tag, stray); end
    checks++; if (idle_cyc - fd_cyc !== 1) begin errors++; $display("FAIL %s busy_fall: busy low %0d cycles after frame_done, want 1", tag, idle_cyc - fd_cyc); end
    if (rcyc.size() > 0) begin
      checks++; if (rcyc[0] !== 1) begin errors++; $display("FAIL %s first_read: at cycle %0d want 1", tag, rcyc[0]); end
    end
    nr = (raddr.size() < N) ? raddr.size() : N;
    for (int i = 0; i < nr; i++) begin
      checks++;
      if (raddr[i] !== AW'(BASE + i)) begin errors++; $display("FAIL %s addr[%0d]: got %0d want %0d", tag, i, raddr[i], BASE + i); end
      if (i > 0 && band_of(i) == band_of(i - 1)) begin
        checks++;
        if (rcyc[i] !== rcyc[i-1] + 1) begin errors++; $display("FAIL %s bubble[%0d]: read at %0d want %0d", tag, i, rcyc[i], rcyc[i-1] + 1); end
      end
    end
    nd = (dat.size() < nr) ? dat.size() : nr;
    for (int i = 0; i < nd; i++) begin
      checks++;
      if (dat[i] !== 8'(BASE + i)) begin errors++; $display("FAIL %s data[%0d]: got %0d want %0d", tag, i, dat[i], 8'(BASE + i)); end
      checks++;
      if ({bd[i], fd[i]} !== {is_band_last(i), i == N - 1}) begin
        errors++; $display("FAIL %s done_flags[%0d]: got band=%b frame=%b want band=%b frame=%b", tag, i, bd[i], fd[i], is_band_last(i), i == N - 1);
      end
      checks++;
      if (fcyc[i] !== rcyc[i] + 1) begin errors++; $display("FAIL %s latency[%0d]: data at %0d want %0d", tag, i, fcyc[i], rcyc[i] + 1); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_rd, bus.fetch_en, busy, bus.band_done, bus.frame_done} !== 5'b0 ||
          bus.data !== 8'd0 || bus.mem_addr !== '0 || row_cnt !== 10'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: rd=%b en=%b busy=%b bd=%b fd=%b data=%0d addr=%0d row=%0d want all 0",
                 i, bus.mem_rd, bus.fetch_en, busy, bus.band_done, bus.frame_done, bus.data, bus.mem_addr, row_cnt);
      end
    end
  endtask

  task automatic test_idle_next();
    next_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
        errors++; $display("FAIL idle_next[%0d]: busy=%b rd=%b want 0 0", i, busy, bus.mem_rd);
      end
    end
    next_i = 1'b0;
  endtask

  task automatic test_prime_lines();
    run_frame(3, 1'b0, 1'b0, "directed");
  endtask

  task automatic test_ignored_controls();
    run_frame(3, 1'b1, 1'b0, "noise_a");
    run_frame(2, 1'b1, 1'b0, "noise_b");
  endtask

  task automatic test_start_with_next();
    run_frame(2, 1'b0, 1'b1, "start_next");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 1'b0, 1'b0, "b2b_a");
    run_frame(0, 1'b1, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    start_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (bus.mem_rd === 1'b1 && bus.mem_addr === AW'(6)) begin hit = 1'b1; break; end
    end
    start_i = 1'b0;
    checks++; if (!hit) begin errors++; $display("FAIL reset_mid_reach: read of address 6 not seen, want seen"); end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #1; else begin @(posedge clk); #1; end
      checks++;
      if ({bus.mem_rd, bus.fetch_en, busy, bus.band_done, bus.frame_done} !== 5'b0 ||
          bus.data !== 8'd0 || bus.mem_addr !== '0 || row_cnt !== 10'd0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: rd=%b en=%b busy=%b bd=%b fd=%b data=%0d addr=%0d want all 0",
                 k, bus.mem_rd, bus.fetch_en, busy, bus.band_done, bus.frame_done, bus.data, bus.mem_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_rd, busy, bus.band_done, bus.frame_done} !== 4'b0) begin
        errors++; $display("FAIL reset_mid_idle[%0d]: rd=%b busy=%b bd=%b fd=%b want 0", k, bus.mem_rd, busy, bus.band_done, bus.frame_done);
      end
    end
    run_frame(3, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_frame($urandom_range(5, 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "random");
  endtask

  initial begin
    test_reset();
    test_idle_next();
    test_prime_lines();
    test_ignored_controls();
    test_start_with_next();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
